// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
// Groups every handshake and bus signal between the core, the arbiter and the
// single-port unified memory.
//   I_*   : instruction-fetch port (req/addr in, rdata/ack out)
//   D_*   : load/store port (req/we/addr/wdata in, rdata/ack out)
//   M_*   : memory side (req/we/addr/wdata out, rdata/ready in, err out)
//   Stall : freeze line toward the core
// Modports: master = arbiter view, slave = core + memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              I_req;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_rdata;
  logic              I_ack;
  logic              D_req;
  logic              D_we;
  logic [ADDR_W-1:0] D_addr;
  logic [DATA_W-1:0] D_wdata;
  logic [DATA_W-1:0] D_rdata;
  logic              D_ack;
  logic              M_req;
  logic              M_we;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_wdata;
  logic [DATA_W-1:0] M_rdata;
  logic              M_ready;
  logic              M_err;
  logic              Stall;

  modport master (
    input  I_req, I_addr, D_req, D_we, D_addr, D_wdata, M_rdata, M_ready,
    output I_rdata, I_ack, D_rdata, D_ack, M_req, M_we, M_addr, M_wdata,
           M_err, Stall
  );

  modport slave (
    output I_req, I_addr, D_req, D_we, D_addr, D_wdata, M_rdata, M_ready,
    input  I_rdata, I_ack, D_rdata, D_ack, M_req, M_we, M_addr, M_wdata,
           M_err, Stall
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the fetch port and the data port.
// Data wins collisions, but after MAX_D_STREAK consecutive data grants with a
// fetch waiting, the fetch is served. An access that sees no M_ready for
// TIMEOUT cycles is completed with ERR_DATA and an M_err pulse.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : unified_mem_arbiter_if.master (core ports, memory ports, Stall)
module unified_mem_arbiter #(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter int              MAX_D_STREAK = 4,
  parameter int              TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEADBEEF
) (
  input logic                   CLK,
  input logic                   RESET,
  unified_mem_arbiter_if.master bus
);

  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [WAIT_W-1:0]   TIMEOUT_C = WAIT_W'(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_C  = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t              state_reg, state_next;
  logic                m_req_reg, m_we_reg, m_err_reg;
  logic [ADDR_W-1:0]   m_addr_reg;
  logic [DATA_W-1:0]   m_wdata_reg;
  logic                i_ack_reg, d_ack_reg;
  logic [DATA_W-1:0]   i_rdata_reg, d_rdata_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [STREAK_W-1:0] streak_reg;

  logic turnaround, i_want, d_want, done, timed_out, grant_i, grant_d;

  // The cycle carrying an ack is a bus turnaround: the acked requester is
  // still dropping its req, so no grant is made until the following cycle.
  assign turnaround = i_ack_reg | d_ack_reg;
  assign i_want     = bus.I_req & ~turnaround;
  assign d_want     = bus.D_req & ~turnaround;

  // M_ready arriving on the timeout cycle is a normal completion.
  assign done      = bus.M_ready | (wait_cnt_reg == TIMEOUT_C);
  assign timed_out = ~bus.M_ready & (wait_cnt_reg == TIMEOUT_C);

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_want && (!i_want || streak_reg != STREAK_C)) begin
          grant_d    = 1'b1;
          state_next = GNT_D;
        end else if (i_want) begin
          grant_i    = 1'b1;
          state_next = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      m_err_reg    <= 1'b0;
      i_ack_reg    <= 1'b0;
      d_ack_reg    <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      wait_cnt_reg <= '0;
      streak_reg   <= '0;
    end else begin
      state_reg <= state_next;
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      m_err_reg <= 1'b0;
      if (grant_i || grant_d) begin
        m_req_reg    <= 1'b1;
        m_we_reg     <= grant_d & bus.D_we;
        m_addr_reg   <= grant_d ? bus.D_addr : bus.I_addr;
        m_wdata_reg  <= grant_d ? bus.D_wdata : '0;
        wait_cnt_reg <= '0;
        // Streak counts data grants that kept a fetch waiting.
        if (grant_i || !bus.I_req)
          streak_reg <= '0;
        else if (streak_reg != STREAK_C)
          streak_reg <= streak_reg + 1'b1;
      end else if (state_reg != IDLE) begin
        if (done) begin
          m_req_reg    <= 1'b0;
          m_we_reg     <= 1'b0;
          m_addr_reg   <= '0;
          m_wdata_reg  <= '0;
          wait_cnt_reg <= '0;
          m_err_reg    <= timed_out;
          if (state_reg == GNT_I) begin
            i_ack_reg   <= 1'b1;
            i_rdata_reg <= timed_out ? ERR_DATA : bus.M_rdata;
          end else begin
            d_ack_reg <= 1'b1;
            if (!m_we_reg)
              d_rdata_reg <= timed_out ? ERR_DATA : bus.M_rdata;
          end
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.M_req   = m_req_reg;
  assign bus.M_we    = m_we_reg;
  assign bus.M_addr  = m_addr_reg;
  assign bus.M_wdata = m_wdata_reg;
  assign bus.M_err   = m_err_reg;
  assign bus.I_ack   = i_ack_reg;
  assign bus.D_ack   = d_ack_reg;
  assign bus.I_rdata = i_rdata_reg;
  assign bus.D_rdata = d_rdata_reg;
  assign bus.Stall   = (bus.I_req & ~i_ack_reg) | (bus.D_req & ~d_ack_reg);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Scoreboard bench: expected grants and acks are queued when requests are
// driven and popped when the arbiter raises M_req or an ack.
module tb_unified_mem_arbiter;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          MAXS = 2;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERR  = 32'hDEADBEEF;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO), .ERR_DATA(ERR)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.master)
  );

  typedef struct {logic [31:0] rdata; logic err; int delta;} ack_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} gnt_t;

  ack_t i_q[$];
  ack_t d_q[$];
  gnt_t g_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] d_rdata_model = '0;
  int mem_lat = 1;
  bit mem_hang = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: M_ready in the mem_lat-th cycle of an M_req.
  initial begin
    int mcnt;
    mcnt = 0;
    bus.M_ready = 1'b0;
    bus.M_rdata = '0;
    for (int k = 0; k < 256; k++) mem[k] = 32'hA500_0000 | k;
    mem[8'h10] = 32'h2009000A;
    forever begin
      @(posedge CLK);
      #1;
      if (!bus.M_req || bus.M_ready) begin
        bus.M_ready = 1'b0;
        mcnt = 0;
      end else begin
        mcnt++;
        if (!mem_hang && mcnt >= mem_lat) begin
          bus.M_ready = 1'b1;
          bus.M_rdata = mem[bus.M_addr[9:2]];
          if (bus.M_we) mem[bus.M_addr[9:2]] = bus.M_wdata;
        end
      end
    end
  end

  // Monitor: grants, acks and bus invariants, sampled on the falling edge.
  initial begin
    logic prev_mreq;
    int rise_cyc;
    gnt_t cur_g;
    ack_t e;
    prev_mreq = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev_mreq = 1'b0;
      end else begin
        check("stall", bus.Stall, (bus.I_req & ~bus.I_ack) | (bus.D_req & ~bus.D_ack));
        check("single_ack", bus.I_ack & bus.D_ack, 1'b0);
        if (bus.M_req && !prev_mreq) begin
          rise_cyc = cyc;
          check("grant_expected", g_q.size() != 0, 1'b1);
          if (g_q.size() != 0) begin
            cur_g = g_q.pop_front();
            check("grant_addr", bus.M_addr, cur_g.addr);
            check("grant_we", bus.M_we, cur_g.we);
            check("grant_wdata", bus.M_wdata, cur_g.wdata);
          end
        end else if (bus.M_req) begin
          check("hold_addr", bus.M_addr, cur_g.addr);
          check("hold_wdata", bus.M_wdata, cur_g.wdata);
        end
        if (!bus.M_req)
          check("m_idle_zero", bus.M_we | (|bus.M_addr) | (|bus.M_wdata), 1'b0);
        if (bus.I_ack) begin
          check("i_ack_expected", i_q.size() != 0, 1'b1);
          if (i_q.size() != 0) begin
            e = i_q.pop_front();
            check("i_rdata", bus.I_rdata, e.rdata);
            check("i_err", bus.M_err, e.err);
            check("i_latency", cyc - rise_cyc, e.delta);
          end
          check("i_ack_mreq_low", bus.M_req, 1'b0);
        end
        if (bus.D_ack) begin
          check("d_ack_expected", d_q.size() != 0, 1'b1);
          if (d_q.size() != 0) begin
            e = d_q.pop_front();
            check("d_rdata", bus.D_rdata, e.rdata);
            check("d_err", bus.M_err, e.err);
            check("d_latency", cyc - rise_cyc, e.delta);
          end
          check("d_ack_mreq_low", bus.M_req, 1'b0);
        end
        if (!bus.I_ack && !bus.D_ack) check("m_err_idle", bus.M_err, 1'b0);
        prev_mreq = bus.M_req;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int n_acks, input int extra,
                       output int ack_cyc);
    ack_t e;
    int seen = 0;
    int n = 0;
    e.rdata = mem_hang ? ERR : ref_mem[a[9:2]];
    e.err   = mem_hang;
    e.delta = mem_hang ? TMO + 1 : mem_lat;
    for (int k = 0; k < n_acks; k++) i_q.push_back(e);
    bus.I_addr = a;
    bus.I_req  = 1'b1;
    while (seen < n_acks && n < 400) begin
      @(posedge CLK);
      #2;
      n++;
      if (bus.I_ack) seen++;
    end
    check("i_ack_count", seen, n_acks);
    ack_cyc = cyc;
    repeat (extra) begin
      @(posedge CLK);
      #2;
    end
    bus.I_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int ack_cyc);
    ack_t e;
    int n = 0;
    if (we) begin
      e.rdata = d_rdata_model;
      ref_mem[a[9:2]] = wd;
    end else begin
      e.rdata = mem_hang ? ERR : ref_mem[a[9:2]];
      d_rdata_model = e.rdata;
    end
    e.err   = mem_hang;
    e.delta = mem_hang ? TMO + 1 : mem_lat;
    d_q.push_back(e);
    bus.D_we    = we;
    bus.D_addr  = a;
    bus.D_wdata = wd;
    bus.D_req   = 1'b1;
    do begin
      @(posedge CLK);
      #2;
      n++;
    end while (!bus.D_ack && n < 400);
    check("d_ack_seen", bus.D_ack, 1'b1);
    ack_cyc = cyc;
    bus.D_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    int c0, ci, cd, dummy;
    bus.I_req = 1'b0; bus.I_addr = '0;
    bus.D_req = 1'b0; bus.D_we = 1'b0; bus.D_addr = '0; bus.D_wdata = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'hA500_0000 | k;
    ref_mem[8'h10] = 32'h2009000A;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_m_req", bus.M_req, 1'b0);
    check("rst_m_addr", bus.M_addr, 32'h0);
    check("rst_acks", {bus.I_ack, bus.D_ack, bus.M_err}, 3'b000);
    check("rst_i_rdata", bus.I_rdata, 32'h0);
    check("rst_d_rdata", bus.D_rdata, 32'h0);
    #1 RESET = 1'b1;
    idle(2);

    // Fetch only: M_ready in cycle 2, ack in cycle 3
    $display("[TB] fetch only");
    mem_lat = 2;
    g_q.push_back('{32'h40, 1'b0, 32'h0});
    c0 = cyc;
    fork
      fetch(32'h40, 1, 0, ci);
      begin
        @(posedge CLK);
        #3;
        check("fetch_mreq_c1", bus.M_req, 1'b1);
        check("fetch_maddr_c1", bus.M_addr, 32'h40);
      end
    join
    check("fetch_ack_cycle", ci - c0, 3);
    idle(3);

    // Collision: data store first, then fetch after the turnaround cycle
    $display("[TB] collision");
    mem_lat = 1;
    g_q.push_back('{32'h100, 1'b1, 32'h55});
    g_q.push_back('{32'h44, 1'b0, 32'h0});
    c0 = cyc;
    fork
      d_access(1'b1, 32'h100, 32'h55, cd);
      fetch(32'h44, 1, 0, ci);
    join
    check("coll_d_ack_cycle", cd - c0, 2);
    check("coll_i_ack_cycle", ci - c0, 5);
    idle(3);

    // Starvation (MAX_D_STREAK=2): D, D, I, D, D, I
    $display("[TB] starvation");
    g_q.push_back('{32'h100, 1'b0, 32'h0});
    g_q.push_back('{32'h104, 1'b0, 32'h0});
    g_q.push_back('{32'h50, 1'b0, 32'h0});
    g_q.push_back('{32'h108, 1'b0, 32'h0});
    g_q.push_back('{32'h10C, 1'b0, 32'h0});
    g_q.push_back('{32'h54, 1'b0, 32'h0});
    fork
      begin
        d_access(1'b0, 32'h100, 32'h0, dummy);
        d_access(1'b0, 32'h104, 32'h0, dummy);
        d_access(1'b0, 32'h108, 32'h0, dummy);
        d_access(1'b0, 32'h10C, 32'h0, dummy);
      end
      begin
        fetch(32'h50, 1, 0, dummy);
        fetch(32'h54, 1, 0, dummy);
      end
    join
    idle(3);

    // Timeout on a silent memory, then M_ready exactly on the timeout cycle
    $display("[TB] timeout");
    mem_hang = 1'b1;
    g_q.push_back('{32'h200, 1'b0, 32'h0});
    d_access(1'b0, 32'h200, 32'h0, dummy);
    mem_hang = 1'b0;
    idle(2);
    mem_lat = TMO + 1;
    g_q.push_back('{32'h204, 1'b0, 32'h0});
    d_access(1'b0, 32'h204, 32'h0, dummy);
    mem_lat = 1;
    idle(3);

    // Back-to-back: req held through the ack cycle only, then held longer
    $display("[TB] back-to-back");
    g_q.push_back('{32'h48, 1'b0, 32'h0});
    fetch(32'h48, 1, 1, dummy);
    idle(4);
    g_q.push_back('{32'h4C, 1'b0, 32'h0});
    g_q.push_back('{32'h4C, 1'b0, 32'h0});
    fetch(32'h4C, 2, 0, dummy);
    idle(3);

    // Reset in the middle of a fetch grant
    $display("[TB] reset mid-access");
    mem_hang = 1'b1;
    g_q.push_back('{32'h60, 1'b0, 32'h0});
    bus.I_addr = 32'h60;
    bus.I_req  = 1'b1;
    idle(3);
    check("pre_rst_mreq", bus.M_req, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check("mid_rst_mreq", bus.M_req, 1'b0);
    check("mid_rst_maddr", bus.M_addr, 32'h0);
    check("mid_rst_acks", {bus.I_ack, bus.D_ack, bus.M_err}, 3'b000);
    check("mid_rst_i_rdata", bus.I_rdata, 32'h0);
    check("mid_rst_d_rdata", bus.D_rdata, 32'h0);
    bus.I_req = 1'b0;
    mem_hang = 1'b0;
    d_rdata_model = '0;
    idle(2);
    RESET = 1'b1;
    idle(5);
    g_q.push_back('{32'h60, 1'b0, 32'h0});
    fetch(32'h60, 1, 0, dummy);
    g_q.push_back('{32'h104, 1'b0, 32'h0});
    d_access(1'b0, 32'h104, 32'h0, dummy);
    idle(5);

    check("scoreboard_empty", i_q.size() + d_q.size() + g_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (PC side) and the data port (load/store side) of the MIPS core.
- Sequences each access with a request/ack handshake toward the core and a request/ready handshake toward the memory.
- Drives a Stall line so the core freezes PC and pipeline state while an access is outstanding.
- Provides data-first priority with starvation protection for fetch, plus a timeout on unresponsive memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (>=1)
TIMEOUT, 255, cycles to wait for M_ready before aborting (>=1)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-low
I_req  in  1  fetch request, level, held until I_ack
I_addr  in  ADDR_W  fetch address
I_rdata  out  DATA_W  fetched instruction, valid when I_ack=1
I_ack  out  1  one-cycle completion pulse
D_req  in  1  data request, level, held until D_ack
D_we  in  1  1=store, 0=load
D_addr  in  ADDR_W  data address
D_wdata  in  DATA_W  store data
D_rdata  out  DATA_W  load data, valid when D_ack=1
D_ack  out  1  one-cycle completion pulse
M_req  out  1  memory request
M_we  out  1  memory write enable
M_addr  out  ADDR_W  memory address
M_wdata  out  DATA_W  memory write data
M_rdata  in  DATA_W  memory read data, sampled when M_ready=1
M_ready  in  1  memory completion, one cycle
M_err  out  1  one-cycle pulse coincident with the ack of a timed-out access
Stall  out  1  combinational: (I_req & ~I_ack) | (D_req & ~D_ack)

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RESET).
- Reset: while RESET=0, state=IDLE and every registered output is 0, including M_req, M_we, M_addr, M_wdata, I_ack, D_ack, I_rdata, D_rdata, M_err. Streak counter and wait counter are also 0.
- Reset mid-transaction: the pending access is dropped. M_req falls immediately (asynchronously). No ack is issued after release, and the requester must re-request.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE arbitration:
  - Only D_req: go to GNT_D.
  - Only I_req: go to GNT_I.
  - Both: GNT_I if streak==MAX_D_STREAK, else GNT_D.
  - Neither: stay in IDLE.
- Ack-cycle rule: a request from a port whose ack is high in the current cycle is ignored. This prevents a duplicate grant while the requester drops req.
- On grant edge: address, we and wdata are latched into the M_* registers. M_req=1 from the next cycle. M_* are held stable while M_req=1 and are 0 when M_req=0. The I port always drives M_we=0.
- GNT_x with M_ready=1:
  - At the next edge, x_ack=1 for one cycle.
  - x_rdata<=M_rdata on loads/fetches. x_rdata is unchanged on stores.
  - M_req<=0 and state<=IDLE.
- Latency: request in cycle 0 → M_req in cycle 1. M_ready in cycle k≥1 → ack in cycle k+1. The minimum is ack in cycle 2.
- Wait counter: cleared on grant, then increments each GNT cycle with M_ready=0. If it reaches TIMEOUT, the access completes as if M_ready had arrived, with rdata=ERR_DATA (loads/fetches) and M_err=1 coincident with the ack. M_ready together with the TIMEOUT edge counts as normal completion with no error.
- Streak counter:
  - +1 on each D grant made while I_req=1, saturating at MAX_D_STREAK.
  - Cleared on every I grant.
  - Cleared on any D grant made while I_req=0.
- M_ready outside GNT states is ignored.
- Acks are never asserted on both ports in the same cycle.

Test Plan:
- Fetch only:
  - Stimulus: I_req=1, I_addr=0x40; memory returns M_ready in cycle 2 with M_rdata=0x2009000A.
  - Response: M_req=1 and M_addr=0x40 in cycles 1-2, M_we=0; I_ack=1 in cycle 3 with I_rdata=0x2009000A; Stall=1 in cycles 0-2.
- Collision:
  - Stimulus: in cycle 0, D store (addr 0x100, data 0x55) and I fetch (addr 0x44) arrive together; memory has 1-cycle ready.
  - Response: D is served first (M_we=1, M_wdata=0x55, D_ack in cycle 2); I is granted next, with M_addr=0x44 and I_ack in cycle 5.
- Starvation:
  - Stimulus: MAX_D_STREAK=2; D_req re-asserted immediately after each ack; I_req held high.
  - Response: grant order is D, D, I, D, D, I.
- Timeout:
  - Stimulus: TIMEOUT=8; D load to 0x200; M_ready held at 0.
  - Response: D_ack and M_err pulse together 9 cycles after M_req rises, with D_rdata=0xDEADBEEF; M_req then falls to 0.
- Reset mid-access:
  - Stimulus: RESET=0 asserted asynchronously while in GNT_I.
  - Response: M_req=0 immediately and all outputs 0; no I_ack after release; a new I_req is served normally.
- Back-to-back:
  - Stimulus: I_req held high one cycle past I_ack.
  - Response: no second grant in the ack cycle; a second grant occurs only if I_req is still high in the following cycle.
